// File: rtl/sram16_pkg.sv
// Shared types and helpers for the 16-bit asynchronous SRAM terminator:
// FSM states, byte-lane encoding, strobe bundle and data steering functions.
package sram16_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_RACK  = 3'd2,
    ST_WR    = 3'd3,
    ST_WHOLD = 3'd4
  } state_e;

  // Active-high lane mask: bit 1 = upper byte D[15:8], bit 0 = lower byte D[7:0].
  typedef enum logic [1:0] {
    LANE_NONE = 2'b00,
    LANE_LO   = 2'b01,
    LANE_HI   = 2'b10,
    LANE_BOTH = 2'b11
  } lane_e;

  // All SRAM control strobes, active low.
  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic ub_n;
    logic lb_n;
  } strobe_t;

  localparam strobe_t SRAM_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1,
                                    ub_n: 1'b1, lb_n: 1'b1};

  // Halfwords use both lanes; bytes pick the lane from the address LSB.
  function automatic lane_e lane_sel(input logic siz, input logic a0);
    if (siz)     return LANE_BOTH;
    else if (a0) return LANE_HI;
    else         return LANE_LO;
  endfunction

  // Strobes for an active access. oe_n and we_n are derived from the same
  // direction bit with opposite polarity, so they can never both be low.
  function automatic strobe_t active_strobes(input logic we, input lane_e lane);
    strobe_t s;
    s.ce_n = 1'b0;
    s.oe_n = we;
    s.we_n = ~we;
    s.ub_n = ~lane[1];
    s.lb_n = ~lane[0];
    return s;
  endfunction

  // Byte writes replicate the byte on both lanes; the lane enables pick one.
  function automatic logic [15:0] steer_wr(input logic siz, input logic [15:0] d);
    return siz ? d : {d[7:0], d[7:0]};
  endfunction

  // Byte reads are right-justified and optionally sign-extended.
  function automatic logic [15:0] format_rd(input lane_e lane, input logic sgn,
                                            input logic [15:0] d);
    logic [7:0] b;
    b = (lane == LANE_HI) ? d[15:8] : d[7:0];
    if (lane == LANE_BOTH) return d;
    return {{8{sgn & b[7]}}, b};
  endfunction

endpackage

// File: rtl/sram16_ctrl_wait_timer.sv
// Loadable down-counter with a zero flag, used to time SRAM strobe widths.
module wait_timer #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_d, cnt_q;

  // Load has priority; decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                      cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sram16_ctrl.sv
// Bus-slave terminator driving an asynchronous 16-bit SRAM with byte enables.
// Each byte/halfword request becomes one timed SRAM cycle followed by a
// single-cycle acknowledge. All outputs come straight from flops.
module sram16_ctrl
  import sram16_pkg::*;
#(
  parameter int AW      = 19,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [63:0]   adr_i,
  input  logic          cyc_i,
  input  logic          stb_i,
  input  logic          we_i,
  input  logic          siz_i,
  input  logic          signed_i,
  input  logic [15:0]   dat_i,
  output logic          ack_o,
  output logic [15:0]   dat_o,
  output logic [AW-1:0] sram_a_o,
  input  logic [15:0]   sram_d_i,
  output logic [15:0]   sram_d_o,
  output logic          sram_d_oe_o,
  output logic          sram_ce_no,
  output logic          sram_oe_no,
  output logic          sram_we_no,
  output logic          sram_lb_no,
  output logic          sram_ub_no
);

  localparam int MAXW = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CW   = $clog2(MAXW) + 1;
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_WAIT - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WR_WAIT - 1);

  state_e        state_d, state_q;
  lane_e         lane_d,  lane_q;
  logic          sgn_d,   sgn_q;
  logic          ack_d,   ack_q;
  logic [15:0]   dat_d,   dat_q;
  logic [AW-1:0] a_d,     a_q;
  logic [15:0]   wd_d,    wd_q;
  logic          doe_d,   doe_q;
  strobe_t       stb_d,   stb_q;

  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_dec;
  logic          tmr_zero;

  // Address bits above the SRAM size are don't-care.
  logic unused_adr;
  assign unused_adr = ^adr_i[63:AW+1];

  wait_timer #(.W(CW)) u_timer (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    sgn_d    = sgn_q;
    ack_d    = 1'b0;
    dat_d    = dat_q;
    a_d      = a_q;
    wd_d     = wd_q;
    doe_d    = doe_q;
    stb_d    = stb_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cyc_i && stb_i) begin
          a_d      = adr_i[AW:1];
          lane_d   = lane_sel(siz_i, adr_i[0]);
          sgn_d    = signed_i;
          tmr_load = 1'b1;
          stb_d    = active_strobes(we_i, lane_sel(siz_i, adr_i[0]));
          if (we_i) begin
            state_d = ST_WR;
            tmr_val = WR_LOAD;
            wd_d    = steer_wr(siz_i, dat_i);
            doe_d   = 1'b1;
          end else begin
            state_d = ST_RD;
            tmr_val = RD_LOAD;
            doe_d   = 1'b0;
          end
        end
      end

      ST_RD: begin
        // Abort wins over completion: no capture, no ack.
        if (!cyc_i) begin
          state_d = ST_IDLE;
          stb_d   = SRAM_IDLE;
        end else if (tmr_zero) begin
          state_d = ST_RACK;
          stb_d   = SRAM_IDLE;
          dat_d   = format_rd(lane_q, sgn_q, sram_d_i);
          ack_d   = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      ST_RACK: begin
        state_d = ST_IDLE;
      end

      ST_WR: begin
        if (!cyc_i) begin
          state_d = ST_IDLE;
          stb_d   = SRAM_IDLE;
          doe_d   = 1'b0;
        end else if (tmr_zero) begin
          // Release we/ce but keep driving data for one hold cycle.
          state_d = ST_WHOLD;
          stb_d   = SRAM_IDLE;
          ack_d   = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      ST_WHOLD: begin
        state_d = ST_IDLE;
        doe_d   = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        stb_d   = SRAM_IDLE;
        doe_d   = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset releases every strobe at once.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      lane_q  <= LANE_NONE;
      sgn_q   <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      a_q     <= '0;
      wd_q    <= '0;
      doe_q   <= 1'b0;
      stb_q   <= SRAM_IDLE;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      sgn_q   <= sgn_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      a_q     <= a_d;
      wd_q    <= wd_d;
      doe_q   <= doe_d;
      stb_q   <= stb_d;
    end
  end

  assign ack_o       = ack_q;
  assign dat_o       = dat_q;
  assign sram_a_o    = a_q;
  assign sram_d_o    = wd_q;
  assign sram_d_oe_o = doe_q;
  assign sram_ce_no  = stb_q.ce_n;
  assign sram_oe_no  = stb_q.oe_n;
  assign sram_we_no  = stb_q.we_n;
  assign sram_lb_no  = stb_q.lb_n;
  assign sram_ub_no  = stb_q.ub_n;

endmodule

// File: tb/tb_sram16_ctrl.sv
// Self-checking bench for sram16_ctrl with a behavioural async SRAM model
// and a scoreboard of expected acknowledges.
module tb_sram16_ctrl;

  localparam int AW      = 19;
  localparam int RD_WAIT = 2;
  localparam int WR_WAIT = 2;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [63:0]   adr_i;
  logic          cyc_i, stb_i, we_i, siz_i, signed_i;
  logic [15:0]   dat_i;
  logic          ack_o;
  logic [15:0]   dat_o;
  logic [AW-1:0] sram_a_o;
  logic [15:0]   sram_d_i, sram_d_o;
  logic          sram_d_oe_o, sram_ce_no, sram_oe_no, sram_we_no;
  logic          sram_lb_no, sram_ub_no;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    bit          is_rd;
    logic [15:0] dat;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  logic [15:0] mem     [0:16383];
  logic [15:0] ref_mem [0:16383];

  sram16_ctrl #(.AW(AW), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .adr_i(adr_i), .cyc_i(cyc_i),
    .stb_i(stb_i), .we_i(we_i), .siz_i(siz_i), .signed_i(signed_i),
    .dat_i(dat_i), .ack_o(ack_o), .dat_o(dat_o), .sram_a_o(sram_a_o),
    .sram_d_i(sram_d_i), .sram_d_o(sram_d_o), .sram_d_oe_o(sram_d_oe_o),
    .sram_ce_no(sram_ce_no), .sram_oe_no(sram_oe_no), .sram_we_no(sram_we_no),
    .sram_lb_no(sram_lb_no), .sram_ub_no(sram_ub_no)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // SRAM model: drives only the enabled lanes while ce and oe are low.
  always_comb begin
    sram_d_i = 16'h0000;
    if (!sram_ce_no && !sram_oe_no) begin
      if (!sram_ub_no) sram_d_i[15:8] = mem[sram_a_o[13:0]][15:8];
      if (!sram_lb_no) sram_d_i[7:0]  = mem[sram_a_o[13:0]][7:0];
    end
  end

  always @(posedge clk_i) begin
    if (!sram_ce_no && !sram_we_no && sram_d_oe_o) begin
      if (!sram_ub_no) mem[sram_a_o[13:0]][15:8] <= sram_d_o[15:8];
      if (!sram_lb_no) mem[sram_a_o[13:0]][7:0]  <= sram_d_o[7:0];
    end
  end

  // Scoreboard consumer and bus-contention watch.
  always @(negedge clk_i) begin
    if (ack_o) begin
      if (sb_q.size() == 0) check("unexpected_ack", 1'b1, 1'b0);
      else begin
        mon_e = sb_q.pop_front();
        if (mon_e.is_rd) check("rd_data", dat_o, mon_e.dat);
      end
    end
    if (!sram_we_no || !sram_oe_no) check("we_oe_excl", sram_we_no | sram_oe_no, 1'b1);
  end

  function automatic logic [15:0] exp_rd(input logic [15:0] w, input bit siz,
                                         input bit a0, input bit sgn);
    logic [7:0] b;
    if (siz) return w;
    b = a0 ? w[15:8] : w[7:0];
    return (sgn && b[7]) ? {8'hFF, b} : {8'h00, b};
  endfunction

  task automatic drive(input bit we, input bit siz, input bit sgn,
                       input logic [63:0] adr, input logic [15:0] dat);
    adr_i = adr; we_i = we; siz_i = siz; signed_i = sgn; dat_i = dat;
    cyc_i = 1'b1; stb_i = 1'b1;
  endtask

  task automatic xfer(input bit we, input bit siz, input bit sgn,
                      input logic [63:0] adr, input logic [15:0] dat);
    int act, ack_at, wt;
    bit lb, ub;
    logic [15:0] exp_do;
    logic [13:0] ha;
    exp_t e;
    ha = adr[14:1];
    lb = siz || !adr[0];
    ub = siz || adr[0];
    exp_do = siz ? dat : {dat[7:0], dat[7:0]};
    wt = we ? WR_WAIT : RD_WAIT;
    if (we) begin
      if (ub) ref_mem[ha][15:8] = siz ? dat[15:8] : dat[7:0];
      if (lb) ref_mem[ha][7:0]  = dat[7:0];
      e.is_rd = 1'b0; e.dat = 16'h0;
    end else begin
      e.is_rd = 1'b1; e.dat = exp_rd(ref_mem[ha], siz, adr[0], sgn);
    end
    sb_q.push_back(e);
    @(negedge clk_i);
    drive(we, siz, sgn, adr, dat);
    @(posedge clk_i);
    act = 0; ack_at = 0;
    for (int i = 1; i <= 4 * wt + 8 && ack_at == 0; i++) begin
      @(negedge clk_i);
      if (!sram_ce_no) begin
        act++;
        check("lanes", {sram_ub_no, sram_lb_no}, {~ub, ~lb});
        check("addr", sram_a_o, adr[AW:1]);
        if (we) begin
          check("we_low", sram_we_no, 1'b0);
          check("wdata", sram_d_o, exp_do);
          check("d_oe_wr", sram_d_oe_o, 1'b1);
        end else begin
          check("oe_low", sram_oe_no, 1'b0);
          check("d_oe_rd", sram_d_oe_o, 1'b0);
        end
      end
      if (ack_o) begin
        ack_at = i;
        check("ack_ce_off", sram_ce_no, 1'b1);
        if (we) check("wr_hold", {sram_we_no, sram_d_oe_o, sram_d_o}, {1'b1, 1'b1, exp_do});
      end
    end
    check("ack_cycle", ack_at, wt + 1);
    check("active_cycles", act, wt);
    @(posedge clk_i); #1;
    cyc_i = 1'b0; stb_i = 1'b0;
    @(negedge clk_i);
    check("ack_one_cycle", ack_o, 1'b0);
    if (we) check("mem_word", mem[ha], ref_mem[ha]);
  endtask

  initial begin
    int a1, a2;
    logic [15:0] prev;
    exp_t e;
    for (int i = 0; i < 16384; i++) begin mem[i] = 16'h0; ref_mem[i] = 16'h0; end
    mem[14'h1111] = 16'hAA55; ref_mem[14'h1111] = 16'hAA55;
    mem[14'h2000] = 16'h1234; ref_mem[14'h2000] = 16'h1234;
    reset_i = 1'b0; adr_i = '0; cyc_i = 0; stb_i = 0; we_i = 0; siz_i = 0;
    signed_i = 0; dat_i = '0;

    // Reset values
    repeat (2) @(negedge clk_i);
    check("rst_ack", ack_o, 1'b0);
    check("rst_dat", dat_o, 16'h0);
    check("rst_addr", sram_a_o, 0);
    check("rst_dout", {sram_d_oe_o, sram_d_o}, 17'h0);
    check("rst_strobes", {sram_ce_no, sram_oe_no, sram_we_no, sram_lb_no, sram_ub_no}, 5'h1F);
    reset_i = 1'b1;
    @(negedge clk_i);

    // Halfword and byte reads
    xfer(0, 1, 0, 64'hFFFF_0000_0000_2222, 16'h0);
    check("hw_rd_val", dat_o, 16'hAA55);
    xfer(0, 0, 1, 64'h0000_0000_0000_2223, 16'h0);
    check("byte_rd_signed", dat_o, 16'hFFAA);
    xfer(0, 0, 0, 64'h0000_0000_0000_2223, 16'h0);
    check("byte_rd_unsigned", dat_o, 16'h00AA);

    // Byte write to the even lane, then read back
    xfer(1, 0, 0, 64'h0000_0000_0000_2222, 16'h00DD);
    check("byte_wr_word", mem[14'h1111], 16'hAADD);
    xfer(0, 0, 1, 64'h0000_0000_0000_2222, 16'h0);
    check("byte_rd_even_signed", dat_o, 16'hFFDD);

    // Halfword write, byte readback of its upper lane
    xfer(1, 1, 0, 64'h0000_0000_0000_4002, 16'hC3A5);
    xfer(0, 0, 0, 64'h0000_0000_0000_4003, 16'h0);
    check("hw_wr_upper", dat_o, 16'h00C3);

    // Back-to-back halfword reads with stb held high
    e.is_rd = 1; e.dat = ref_mem[14'h1111]; sb_q.push_back(e);
    e.is_rd = 1; e.dat = ref_mem[14'h2000]; sb_q.push_back(e);
    @(negedge clk_i);
    drive(0, 1, 0, 64'h2222, 16'h0);
    @(posedge clk_i);
    a1 = 0; a2 = 0;
    for (int i = 1; i <= 30 && a2 == 0; i++) begin
      @(negedge clk_i);
      if (ack_o) begin
        if (a1 == 0) begin
          a1 = i;
          @(posedge clk_i); #1 adr_i = 64'h4000;
        end else begin
          a2 = i;
          @(posedge clk_i); #1 cyc_i = 0; stb_i = 0;
        end
      end
    end
    check("b2b_first_ack", a1, RD_WAIT + 1);
    check("b2b_spacing", a2 - a1, RD_WAIT + 2);
    check("b2b_last_data", dat_o, 16'h1234);

    // Abort a read on its second strobe cycle
    @(negedge clk_i);
    prev = dat_o;
    drive(0, 1, 0, 64'h2222, 16'h0);
    @(posedge clk_i);
    @(negedge clk_i);
    check("abort_ce_active", sram_ce_no, 1'b0);
    @(negedge clk_i);
    cyc_i = 0; stb_i = 0;
    @(negedge clk_i);
    check("abort_no_ack", ack_o, 1'b0);
    check("abort_strobes", {sram_ce_no, sram_oe_no, sram_lb_no, sram_ub_no}, 4'hF);
    check("abort_dat_kept", dat_o, prev);
    @(negedge clk_i);
    check("abort_no_late_ack", ack_o, 1'b0);

    // Reset in the middle of a write
    drive(1, 1, 0, 64'h6000, 16'hBEEF);
    @(posedge clk_i);
    @(negedge clk_i);
    check("wr_we_active", sram_we_no, 1'b0);
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    check("rst_mid_strobes", {sram_ce_no, sram_oe_no, sram_we_no, sram_lb_no, sram_ub_no}, 5'h1F);
    check("rst_mid_ack_doe", {ack_o, sram_d_oe_o}, 2'b00);
    cyc_i = 0; stb_i = 0;
    @(negedge clk_i);
    check("rst_mid_no_ack", ack_o, 1'b0);
    reset_i = 1'b1;
    @(negedge clk_i);

    // Transfer after reset release
    xfer(0, 1, 0, 64'h2222, 16'h0);
    check("post_rst_rd", dat_o, 16'hAADD);

    repeat (3) @(negedge clk_i);
    check("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
